// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned GATE_CYCLES_DEFAULT = 100000000;
  // Wide enough for the largest legal gate (2^27-1 cycles).
  localparam int GATE_W = 27;

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle between a measurement requester and freq_meter_core.
interface freq_meter_if #(
  parameter int CNT_W = 24
);
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] freq;
  logic             overflow;

  modport master (output start, input busy, done, freq, overflow);
  modport slave  (input start, output busy, done, freq, overflow);
endinterface

// File: rtl/freq_meter_sig_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for the signal under test.
module sig_sync_edge (
  input  logic sysclk,
  input  logic reset,
  input  logic sigin,
  output logic edge_pulse
);

  logic meta_q, sync_q, prev_q, edge_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= sigin;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= sync_q & ~prev_q;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/freq_meter_core.sv
// Gated rising-edge counter: counts sigin edges over GATE_CYCLES sysclk cycles.
// Define FREQ_METER_CONT_EN for back-to-back measurements after the first start.
//   state | meaning
//   IDLE  | waiting for start, last result held
//   COUNT | gate open, counting edge pulses
//   DONE  | one-cycle result strobe
module freq_meter_core
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int          CNT_W       = 24
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         sigin,
  freq_meter_if.slave  bus
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    edges_q, edges_d;
  logic [CNT_W-1:0]    freq_q, freq_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic                ovf_q, ovf_d;
  logic                edge_pulse;
  logic [CNT_W-1:0]    edges_inc;
  logic                ovf_hit;
  logic                busy_c, done_c;

  sig_sync_edge u_sync (
    .sysclk     (sysclk),
    .reset      (reset),
    .sigin      (sigin),
    .edge_pulse (edge_pulse)
  );

  // Saturating increment; an edge arriving at full scale marks the result overflowed.
  always_comb begin
    edges_inc = edges_q;
    ovf_hit   = 1'b0;
    if (edge_pulse) begin
      if (edges_q == CNT_MAX) ovf_hit = 1'b1;
      else                    edges_inc = edges_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      edges_q   <= '0;
      freq_q    <= '0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      edges_q   <= edges_d;
      freq_q    <= freq_d;
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    edges_d   = edges_q;
    freq_d    = freq_q;
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = COUNT;
          gate_d    = '0;
          edges_d   = '0;
          ovf_acc_d = 1'b0;
        end
      end
      COUNT: begin
        busy_c    = 1'b1;
        gate_d    = gate_q + 1'b1;
        edges_d   = edges_inc;
        ovf_acc_d = ovf_acc_q | ovf_hit;
        if (gate_q == GATE_LAST) begin
          freq_d  = edges_inc;
          ovf_d   = ovf_acc_q | ovf_hit;
          state_d = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
`ifdef FREQ_METER_CONT_EN
        state_d   = COUNT;
        gate_d    = '0;
        edges_d   = '0;
        ovf_acc_d = 1'b0;
`else
        state_d   = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.freq     = freq_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_freq_meter_core.sv
// Scoreboard bench for freq_meter_core: three instances (wide, 4-bit saturating, short gate).
module tb_freq_meter_core;

  logic clk;
  logic reset;
  logic sigin;
  logic start_x;
  int   sel;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   start_cyc = 0;

  int   sig_period = 0;
  logic sig_level  = 1'b0;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
  } exp_t;
  exp_t sb[$];

  freq_meter_if #(.CNT_W(24)) if_a ();
  freq_meter_if #(.CNT_W(4))  if_b ();
  freq_meter_if #(.CNT_W(24)) if_c ();

  freq_meter_core #(.GATE_CYCLES(1000), .CNT_W(24)) dut_a (
    .sysclk(clk), .reset(reset), .sigin(sigin), .bus(if_a));
  freq_meter_core #(.GATE_CYCLES(1000), .CNT_W(4)) dut_b (
    .sysclk(clk), .reset(reset), .sigin(sigin), .bus(if_b));
  freq_meter_core #(.GATE_CYCLES(100), .CNT_W(24)) dut_c (
    .sysclk(clk), .reset(reset), .sigin(sigin), .bus(if_c));

  assign if_a.start = start_x && (sel == 0);
  assign if_b.start = start_x && (sel == 1);
  assign if_c.start = start_x && (sel == 2);

  logic        m_busy, m_done, m_ovf;
  logic [23:0] m_freq;

  always_comb begin
    m_busy = if_a.busy;
    m_done = if_a.done;
    m_ovf  = if_a.overflow;
    m_freq = if_a.freq;
    case (sel)
      1: begin
        m_busy = if_b.busy;
        m_done = if_b.done;
        m_ovf  = if_b.overflow;
        m_freq = 24'(if_b.freq);
      end
      2: begin
        m_busy = if_c.busy;
        m_done = if_c.done;
        m_ovf  = if_c.overflow;
        m_freq = if_c.freq;
      end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Signal source: free-running square wave (period in sysclk cycles) or a static level.
  initial begin
    sigin = 1'b0;
    #3;
    forever begin
      if (sig_period == 0) begin
        sigin = sig_level;
        #10;
      end else begin
        #(sig_period * 5);
        sigin = ~sigin;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_meas(input int s, input bit push, input int lo, input int hi, input bit ovf);
    exp_t e;
    sel = s;
    if (push) begin
      e.lo = lo; e.hi = hi; e.ovf = ovf;
      sb.push_back(e);
    end
    start_cyc = cyc;
    start_x = 1'b1;
    tick(1);
    start_x = 1'b0;
    checks++;
    if (m_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start sel=%0d got=%b want=1", s, m_busy);
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      sig_level = 1'b1;
      tick(4);
      sig_level = 1'b0;
      tick(4);
    end
  endtask

  task automatic wait_result(input string name, input int lat, input int restart_at, input bit single);
    int   n;
    bit   seen;
    exp_t e;
    n = 0;
    seen = 1'b0;
    while (!seen && n < lat + 50) begin
      tick(1);
      n = cyc - start_cyc;
      start_x = (restart_at > 0 && n == restart_at);
      if (m_done === 1'b1) seen = 1'b1;
    end
    start_x = 1'b0;
    checks++;
    if (!seen || n != lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d seen=%0b want=%0d", name, n, seen, lat);
    end
    if (seen) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s_scoreboard got=empty want=entry", name);
      end else begin
        e = sb.pop_front();
        if (int'(m_freq) < e.lo || int'(m_freq) > e.hi || m_ovf !== e.ovf) begin
          errors++;
          $display("FAIL %s_result got freq=%0d ovf=%b want freq=%0d..%0d ovf=%b",
                   name, m_freq, m_ovf, e.lo, e.hi, e.ovf);
        end
      end
      checks++;
      if (m_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_in_done got=%b want=0", name, m_busy);
      end
    end
    if (single) begin
      tick(1);
      checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_after_done got done=%b busy=%b want done=0 busy=0", name, m_done, m_busy);
      end
    end
  endtask

  task automatic set_static(input logic lvl);
    sig_period = 0;
    sig_level  = lvl;
    tick(150);
  endtask

  task automatic set_square(input int p);
    sig_period = p;
    tick(150);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_x = 1'b1;
    sel = 0;
    tick(3);
    start_x = 1'b0;
    reset = 1'b0;
    tick(1);
    checks++;
    if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.freq !== 24'd0 || if_a.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got busy=%b done=%b freq=%0d ovf=%b want 0/0/0/0",
               if_a.busy, if_a.done, if_a.freq, if_a.overflow);
    end
    checks++;
    if (if_b.busy !== 1'b0 || if_b.freq !== 4'd0 || if_c.busy !== 1'b0 || if_c.freq !== 24'd0) begin
      errors++;
      $display("FAIL reset_bc got busy_b=%b freq_b=%0d busy_c=%b freq_c=%0d want 0",
               if_b.busy, if_b.freq, if_c.busy, if_c.freq);
    end
  endtask

  task automatic test_period20();
    set_square(20);
    start_meas(0, 1'b1, 49, 51, 1'b0);
    wait_result("period20", 1001, 0, 1'b1);
    tick(100);
    checks++;
    if (int'(m_freq) < 49 || int'(m_freq) > 51 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_result got freq=%0d busy=%b want 49..51 busy=0", m_freq, m_busy);
    end
  endtask

  task automatic test_constant();
    set_static(1'b1);
    start_meas(0, 1'b1, 0, 0, 1'b0);
    wait_result("const_high", 1001, 0, 1'b1);
    set_square(20);
    start_meas(0, 1'b1, 49, 51, 1'b0);
    wait_result("refill", 1001, 0, 1'b1);
    set_static(1'b0);
    start_meas(0, 1'b1, 0, 0, 1'b0);
    wait_result("const_low", 1001, 0, 1'b1);
  endtask

  task automatic test_restart_ignored();
    int extra;
    set_square(20);
    start_meas(0, 1'b1, 49, 51, 1'b0);
    wait_result("restart", 1001, 500, 1'b1);
    extra = 0;
    repeat (1100) begin
      tick(1);
      if (m_done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL restart_extra_done got=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    set_square(20);
    start_meas(0, 1'b0, 0, 0, 1'b0);
    tick(299);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_freq !== 24'd0 || m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b freq=%0d ovf=%b want 0/0/0/0",
               m_busy, m_done, m_freq, m_ovf);
    end
    extra = 0;
    repeat (1100) begin
      tick(1);
      if (m_done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_done got=%0d want=0", extra);
    end
    start_meas(0, 1'b1, 49, 51, 1'b0);
    wait_result("after_reset", 1001, 0, 1'b1);
  endtask

  task automatic test_saturate();
    set_square(20);
    start_meas(1, 1'b1, 15, 15, 1'b1);
    wait_result("sat_p20", 1001, 0, 1'b1);
    set_square(80);
    start_meas(1, 1'b1, 12, 13, 1'b0);
    wait_result("sat_clear", 1001, 0, 1'b1);
    set_static(1'b0);
    start_meas(1, 1'b1, 15, 15, 1'b0);
    tick(20);
    pulses(15);
    wait_result("sat_15", 1001, 0, 1'b1);
    start_meas(1, 1'b1, 15, 15, 1'b1);
    tick(20);
    pulses(16);
    wait_result("sat_16", 1001, 0, 1'b1);
  endtask

  task automatic test_exact_short_gate();
    set_static(1'b0);
    start_meas(2, 1'b1, 5, 5, 1'b0);
    tick(20);
    pulses(5);
    wait_result("short_5", 101, 0, 1'b1);
    start_meas(2, 1'b1, 0, 0, 1'b0);
    wait_result("short_0", 101, 0, 1'b1);
  endtask

  task automatic test_continuous();
    set_square(80);
    start_meas(0, 1'b1, 12, 13, 1'b0);
    sb.push_back('{lo: 12, hi: 13, ovf: 1'b0});
    sb.push_back('{lo: 12, hi: 13, ovf: 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_result("cont", 1001, 0, 1'b0);
      start_cyc = cyc;
      tick(1);
      checks++;
      if (m_busy !== 1'b1) begin
        errors++;
        $display("FAIL cont_busy got=%b want=1", m_busy);
      end
      start_cyc = cyc - 1;
    end
  endtask

  initial begin
    reset = 1'b1;
    start_x = 1'b0;
    sel = 0;
    test_reset();
`ifdef FREQ_METER_CONT_EN
    test_continuous();
`else
    test_period20();
    test_constant();
    test_restart_ignored();
    test_reset_mid();
    test_saturate();
    test_exact_short_gate();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
